// File: rtl/full_adder_pkg.sv
// Shared constants and golden-sum helper for the full_adder cell.
// Imported by full_adder and by benches that need a reference sum.
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;
    localparam int FA_MAX_WIDTH     = 64;

    // Returns {cout, sum} of a+b+c taken over w bits, packed into the low
    // w+1 bits of the result; upper bits are zero. Operand bits at or above
    // w are ignored.
    function automatic logic [FA_MAX_WIDTH:0] fa_ref(
        input logic [FA_MAX_WIDTH-1:0] a,
        input logic [FA_MAX_WIDTH-1:0] b,
        input logic                    c,
        input int unsigned             w
    );
        logic [FA_MAX_WIDTH:0] m;
        logic [FA_MAX_WIDTH:0] s;
        m = ({{FA_MAX_WIDTH{1'b0}}, 1'b1} << w) - 1'b1;
        s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{FA_MAX_WIDTH{1'b0}}, c};
        s = s & ((m << 1) | {{FA_MAX_WIDTH{1'b0}}, 1'b1});
        return s;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational 1-bit full-adder cell used as one link of the ripple chain.
// Ports: a, b operand bits; ci carry in; s sum bit; co carry out.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout,out} = in1+in2+cin, 1-cycle latency.
// Ports: clk, rst_n (async low), in_valid, in1, in2, cin -> out, cout, out_valid;
// ovf (signed overflow) only when FULL_ADDER_OVF_EN is defined.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic [WIDTH-1:0] out,
    output logic             cout,
`ifdef FULL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_bit u_bit (
            .a  (in1[i]),
            .b  (in2[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out  <= s;
                cout <= c[WIDTH];
            end
        end
    end

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    // For WIDTH=1 the carry into the sign bit is cin itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH 1, 4 and 8.
// Arithmetic reference model plus directed literal vectors.
module tb_full_adder;
    import full_adder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v1 = 0, a1 = 0, b1 = 0, c1 = 0;
    logic       o1, co1, ov1, f1;
    logic       v4 = 0, c4 = 0;
    logic [3:0] a4 = 0, b4 = 0, o4;
    logic       co4, ov4, f4;
    logic       v8 = 0, c8 = 0;
    logic [7:0] a8 = 0, b8 = 0, o8;
    logic       co8, ov8, f8;

    int checks = 0;
    int errors = 0;

    full_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in1(a1), .in2(b1),
        .cin(c1), .out(o1), .cout(co1),
`ifdef FULL_ADDER_OVF_EN
        .ovf(f1),
`endif
        .out_valid(ov1)
    );
    full_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in1(a4), .in2(b4),
        .cin(c4), .out(o4), .cout(co4),
`ifdef FULL_ADDER_OVF_EN
        .ovf(f4),
`endif
        .out_valid(ov4)
    );
    full_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in1(a8), .in2(b8),
        .cin(c8), .out(o8), .cout(co8),
`ifdef FULL_ADDER_OVF_EN
        .ovf(f8),
`endif
        .out_valid(ov8)
    );

`ifndef FULL_ADDER_OVF_EN
    assign f1 = 1'b0;
    assign f4 = 1'b0;
    assign f8 = 1'b0;
`endif

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, exp, $time);
        end
    endtask

    // Signed overflow from integer ranges, independent of carry bits.
    function automatic logic sovf(input longint a, input longint b,
                                  input longint c, input int w);
        longint sa, sb, r, hi, lo;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        sa = (a > hi) ? a - (longint'(1) << w) : a;
        sb = (b > hi) ? b - (longint'(1) << w) : b;
        r  = sa + sb + c;
        return (r > hi) || (r < lo);
    endfunction

    // Reference model: expected {cout,out}, valid and ovf per instance.
    logic [1:0] e1;
    logic [4:0] e4;
    logic [8:0] e8;
    logic       e1v, e4v, e8v, eo1, eo4, eo8;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1 <= '0; e4 <= '0; e8 <= '0;
            e1v <= 0; e4v <= 0; e8v <= 0;
            eo1 <= 0; eo4 <= 0; eo8 <= 0;
        end else begin
            e1v <= v1; e4v <= v4; e8v <= v8;
            if (v1) begin
                e1  <= 2'(a1) + 2'(b1) + 2'(c1);
                eo1 <= sovf(longint'(a1), longint'(b1), longint'(c1), 1);
            end
            if (v4) begin
                e4  <= 5'(a4) + 5'(b4) + 5'(c4);
                eo4 <= sovf(longint'(a4), longint'(b4), longint'(c4), 4);
            end
            if (v8) begin
                e8  <= 9'(a8) + 9'(b8) + 9'(c8);
                eo8 <= sovf(longint'(a8), longint'(b8), longint'(c8), 8);
            end
        end
    end

    always @(negedge clk) begin
        chk("w1_sum",   64'({co1, o1}), 64'(e1));
        chk("w1_valid", 64'(ov1), 64'(e1v));
        chk("w4_sum",   64'({co4, o4}), 64'(e4));
        chk("w4_valid", 64'(ov4), 64'(e4v));
        chk("w8_sum",   64'({co8, o8}), 64'(e8));
        chk("w8_valid", 64'(ov8), 64'(e8v));
`ifdef FULL_ADDER_OVF_EN
        chk("w1_ovf", 64'(f1), 64'(eo1));
        chk("w4_ovf", 64'(f4), 64'(eo4));
        chk("w8_ovf", 64'(f8), 64'(eo8));
`endif
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int ta[8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int tb[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
    int tc[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
    int te[8] = '{1, 1, 2, 1, 2, 2, 3, 0};

    initial begin
        #3;
        chk("rst_w1", 64'({co1, o1, ov1}), 64'd0);
        chk("rst_w8", 64'({co8, o8, ov8}), 64'd0);
        #9 rst_n = 1'b1;

        // WIDTH=1 truth table
        v1 = 1;
        for (int i = 0; i < 8; i++) begin
            a1 = ta[i][0]; b1 = tb[i][0]; c1 = tc[i][0];
            cyc();
            chk("w1_tab", 64'({co1, o1}), 64'(te[i]));
            chk("w1_tab_v", 64'(ov1), 64'd1);
        end

        // asynchronous reset mid-cycle with a valid input in flight
        a1 = 1; b1 = 1; c1 = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_w1", 64'({co1, o1, ov1}), 64'd0);
        cyc();
        chk("arst_hold", 64'({co1, o1, ov1}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_111", 64'({co1, o1}), 64'd3);

        // pulse then idle: result held, valid drops
        a1 = 1; b1 = 1; c1 = 0;
        cyc();
        chk("pulse_sum", 64'({co1, o1}), 64'd2);
        chk("pulse_v",   64'(ov1), 64'd1);
        v1 = 0; a1 = 0; b1 = 0; c1 = 0;
        cyc();
        chk("hold_sum", 64'({co1, o1}), 64'd2);
        chk("hold_v",   64'(ov1), 64'd0);

        // WIDTH=4 carry chain and signed overflow
        v4 = 1; a4 = 4'hF; b4 = 4'h0; c4 = 1;
        cyc();
        chk("w4_ripple", 64'({co4, o4}), 64'h10);
        a4 = 4'h7; b4 = 4'h8; c4 = 0;
        cyc();
        chk("w4_7p8", 64'({co4, o4}), 64'h0F);
        a4 = 4'h7; b4 = 4'h1; c4 = 0;
        cyc();
        chk("w4_7p1", 64'({co4, o4}), 64'h08);
`ifdef FULL_ADDER_OVF_EN
        chk("w4_7p1_ovf", 64'(f4), 64'd1);
`endif
        a4 = 4'h8; b4 = 4'h8; c4 = 0;
        cyc();
        chk("w4_8p8", 64'({co4, o4}), 64'h10);
`ifdef FULL_ADDER_OVF_EN
        chk("w4_8p8_ovf", 64'(f4), 64'd1);
`endif
        v4 = 0;

        // WIDTH=8 boundaries
        v8 = 1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1;
        cyc();
        chk("w8_max", 64'({co8, o8}), 64'h1FF);
        a8 = 8'h00; b8 = 8'h00; c8 = 0;
        cyc();
        chk("w8_zero", 64'({co8, o8}), 64'h000);
        a8 = 8'hFF; b8 = 8'h00; c8 = 1;
        cyc();
        chk("w8_ripple", 64'({co8, o8}), 64'h100);
        chk("pkg_ref", 64'(fa_ref(64'hFF, 64'h00, 1'b1, 8)), 64'({co8, o8}));

        // random sweep, WIDTH=8 always valid
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            cyc();
        end

        // random mix with idle cycles on all widths
        for (int i = 0; i < 300; i++) begin
            v1 = 1'($urandom); a1 = 1'($urandom);
            b1 = 1'($urandom); c1 = 1'($urandom);
            v4 = 1'($urandom); a4 = 4'($urandom);
            b4 = 4'($urandom); c4 = 1'($urandom);
            v8 = ($urandom_range(3) != 0); a8 = 8'($urandom);
            b8 = 8'($urandom); c8 = 1'($urandom);
            cyc();
        end

        v1 = 0; v4 = 0; v8 = 0;
        cyc();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
